// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Instruction-fetch stage. Owns the program counter, drives the
//             instruction-read address of a word-addressed memory, captures
//             the combinationally returned word into a small FIFO and hands
//             entries to decode through a valid/ready handshake. Supports
//             redirect (flush + PC load) and a fetch-enable gate.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             fetch_en          - allow new fetches (queue drains regardless)
//             mem_pc/mem_instr  - memory read address / returned word
//             redirect_en/_pc   - flush queue and restart fetch at _pc
//             dec_valid/ready   - decode handshake
//             dec_instr/dec_pc  - head entry (zero while empty)
//             q_count           - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int RESET_PC  = 0,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [ADDR_W-1:0]          mem_pc,
    input  logic [31:0]                mem_instr,
    input  logic                       redirect_en,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [31:0]                dec_instr,
    output logic [ADDR_W-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] c_reset_pc  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] c_last_pc   = ADDR_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage carries no reset: occupancy alone decides what is visible.
    logic [31:0]       r_instr_q [DEPTH];
    logic [ADDR_W-1:0] r_pc_q    [DEPTH];

    logic              w_valid;
    logic              w_pop;
    logic              w_fetch;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_redirect_pc;

    assign w_valid = (r_count != '0);

    // Redirect outranks both sides of the queue; a head entry offered in a
    // redirect cycle is dropped by the flush rather than consumed.
    assign w_pop   = w_valid & dec_ready & ~redirect_en;
    // A pop in the same cycle frees a slot, so a full queue can still fetch.
    assign w_fetch = fetch_en & ~redirect_en & ((r_count < c_depth) | w_pop);

    // Wrap is modulo the memory depth, not the address-bus width.
    assign w_pc_next     = (r_pc >= c_last_pc) ? '0 : (r_pc + ADDR_W'(1));
    assign w_redirect_pc = redirect_pc % c_mem_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= c_reset_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_en) begin
            r_pc     <= w_redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fetch) begin
                r_pc     <= w_pc_next;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_fetch, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fetch && !rst) begin
            r_instr_q[r_wr_ptr] <= mem_instr;
            r_pc_q[r_wr_ptr]    <= r_pc;
        end
    end

    assign mem_pc    = r_pc;
    assign q_count   = r_count;
    assign dec_valid = w_valid;
    assign dec_instr = w_valid ? r_instr_q[r_rd_ptr] : 32'h0;
    assign dec_pc    = w_valid ? r_pc_q[r_rd_ptr]    : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Directed self-checking bench for instr_fetch_queue with a
//             behavioural 1024-word instruction memory (mem[i] = C0DE_0000+i).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] mem_pc;
    logic [31:0] mem_instr;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [1:0]  q_count;

    logic [31:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_queue #(
        .ADDR_W    (32),
        .MEM_WORDS (1024),
        .RESET_PC  (0),
        .DEPTH     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .mem_pc      (mem_pc),
        .mem_instr   (mem_instr),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .q_count     (q_count)
    );

    assign mem_instr = mem[mem_pc[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;

        rst         = 1'b1;
        fetch_en    = 1'b0;
        dec_ready   = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_mem_pc",    mem_pc,    0);
        chk("rst_q_count",   q_count,   0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_instr", dec_instr, 0);
        chk("rst_dec_pc",    dec_pc,    0);

        // ---- reset and stream ----
        rst       = 1'b0;
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        tick();
        chk("str_mem_pc1", mem_pc, 1);
        chk("str_instr0",  dec_instr, 32'hC0DE_0000);
        chk("str_pc0",     dec_pc, 0);
        tick();
        chk("str_mem_pc2", mem_pc, 2);
        chk("str_instr1",  dec_instr, 32'hC0DE_0001);
        chk("str_pc1",     dec_pc, 1);
        tick();
        chk("str_mem_pc3", mem_pc, 3);
        chk("str_instr2",  dec_instr, 32'hC0DE_0002);
        tick();
        chk("str_instr3",  dec_instr, 32'hC0DE_0003);
        chk("str_pc3",     dec_pc, 3);
        chk("str_count",   q_count, 1);

        // ---- backpressure from reset ----
        rst       = 1'b1;
        dec_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("bp_count1", q_count, 1);
        tick();
        chk("bp_count2", q_count, 2);
        chk("bp_mem_pc", mem_pc, 2);
        tick();
        chk("bp_hold_pc",    mem_pc, 2);
        chk("bp_hold_count", q_count, 2);
        chk("bp_hold_instr", dec_instr, 32'hC0DE_0000);
        chk("bp_hold_decpc", dec_pc, 0);
        dec_ready = 1'b1;
        #1;
        chk("bp_rel_instr0", dec_instr, 32'hC0DE_0000);
        tick();
        chk("bp_rel_instr1", dec_instr, 32'hC0DE_0001);
        chk("bp_rel_count",  q_count, 2);
        chk("bp_rel_mem_pc", mem_pc, 3);
        tick();
        chk("bp_rel_instr2", dec_instr, 32'hC0DE_0002);
        chk("bp_rel_mem_pc2", mem_pc, 4);

        // ---- halt: queue {2,3}, PC=4 ----
        fetch_en = 1'b0;
        tick();
        chk("halt_count1", q_count, 1);
        chk("halt_pc3",    dec_pc, 3);
        chk("halt_mem_pc", mem_pc, 4);
        tick();
        chk("halt_valid0",  dec_valid, 0);
        chk("halt_count0",  q_count, 0);
        tick();
        chk("halt_mem_pc2", mem_pc, 4);
        chk("halt_instr0",  dec_instr, 0);
        chk("halt_decpc0",  dec_pc, 0);
        fetch_en  = 1'b1;
        dec_ready = 1'b0;
        tick();
        chk("resume_pc",    dec_pc, 4);
        chk("resume_instr", dec_instr, 32'hC0DE_0004);
        tick();
        chk("resume_count", q_count, 2);
        chk("resume_mem_pc", mem_pc, 6);

        // ---- redirect with full queue {4,5} ----
        dec_ready   = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_en = 1'b0;
        chk("rd_count0", q_count, 0);
        chk("rd_valid0", dec_valid, 0);
        chk("rd_mem_pc", mem_pc, 32'h20);
        tick();
        chk("rd_instr", dec_instr, 32'hC0DE_0020);
        chk("rd_decpc", dec_pc, 32'h20);
        chk("rd_count1", q_count, 1);

        // ---- wrap at MEM_WORDS-1 ----
        redirect_en = 1'b1;
        redirect_pc = 32'd1023;
        tick();
        redirect_en = 1'b0;
        chk("wrap_mem_pc", mem_pc, 1023);
        tick();
        chk("wrap_decpc1023", dec_pc, 1023);
        chk("wrap_instr",     dec_instr, 32'hC0DE_03FF);
        chk("wrap_mem_pc0",   mem_pc, 0);
        tick();
        chk("wrap_decpc0", dec_pc, 0);
        tick();
        chk("wrap_decpc1", dec_pc, 1);

        // ---- redirect target beyond memory depth ----
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0405;
        tick();
        redirect_en = 1'b0;
        chk("rdmod_mem_pc", mem_pc, 5);

        // ---- async reset mid-stream with full queue ----
        dec_ready = 1'b0;
        tick();
        tick();
        chk("ar_count2", q_count, 2);
        chk("ar_mem_pc", mem_pc, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid",  dec_valid, 0);
        chk("ar_count",  q_count, 0);
        chk("ar_mem_pc0", mem_pc, 0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
